sevenseg_rx: RTL and testbench
==============================

# sevenseg_rx

Receive-side decoder for the dual multiplexed seven-segment bus that the game core drives on `uo_out`. It samples the 8-bit bus `{select, segments[6:0]}` and requires each pattern to hold for a set number of cycles before accepting it. It converts each accepted pattern back to a digit code, rebuilds the tens/ones pair, and flags patterns that do not decode. It is used in self-check and loopback builds, and by the verification bench as a bus monitor.

## Interface
- `STABLE_N`, default 2: consecutive identical samples needed to accept a pattern; legal range 1..15. The default matches the 2-cycle phase of the divide-by-4 display clock.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `seg_in`  in  8  bus sample. Bit 7 = select (1 = tens, 0 = ones); bits 6:0 = segments g..a, active-high.
- `tens`  out  4  last accepted tens digit; 4'hF = blank.
- `ones`  out  4  last accepted ones digit; 4'hF = blank.
- `tens_vld`  out  1  a tens pattern has been accepted since reset.
- `ones_vld`  out  1  a ones pattern has been accepted since reset.
- `pair_stb`  out  1  one-cycle pulse when a complete frame yields a new {tens, ones} pair.
- `err_stb`  out  1  one-cycle pulse when an undecodable pattern is accepted.
- `err_cnt`  out  8  count of accepted undecodable patterns; saturates at 255.

## Operation
- **Sample register:** `s_q <= seg_in` every cycle.
- **Run counter** (4 bits):
  - `run <= (seg_in == s_q) ? min(run+1, STABLE_N) : 1`.
  - Reset sets `run = 0` and `s_q = 0`, so the first post-reset sample always starts a fresh run.
- **Accept event:** occurs in the cycle where `run` transitions to exactly `STABLE_N`.
  - Fires once per run. A held pattern never re-accepts.
  - The select bit is part of the compared byte, so a select change always starts a new run.
- **Decode** (segments, hex):
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9.
  - 00→4'hF (blank, valid).
  - Any other pattern is invalid.
- **Valid accept:** writes the selected digit register and sets its `_vld` flag.
- **Invalid accept:**
  - Pulses `err_stb` and increments `err_cnt` (saturating).
  - Leaves the digit registers and `_vld` flags unchanged.
  - Forces the FSM to WAIT_T.
- **Frame FSM** (2 states):
  - WAIT_T:
    - Valid tens accept → WAIT_O.
    - Valid ones accept → update `ones` only, stay.
  - WAIT_O:
    - Valid ones accept → WAIT_T and frame complete.
    - Valid tens accept → overwrite `tens` (frame restarts), stay.
  - Frame complete: compare the new {tens, ones} with `last_pair`. Pulse `pair_stb` if it differs or if it is the first complete frame since reset, then update `last_pair`.
- **Outputs on reset:**
  - `tens = ones = 4'hF`.
  - `tens_vld`, `ones_vld`, `pair_stb`, `err_stb` = 0.
  - `err_cnt = 0`.
  - FSM = WAIT_T; `last_pair` marked empty.
- **Reset mid-run:** all progress is discarded. The next accept needs `STABLE_N` fresh identical samples after reset deasserts.

## Timing
- A pattern first sampled at edge k is accepted at edge k+STABLE_N-1, provided it is unchanged through that edge.
  - Digit registers, `_vld`, `err_stb`, `err_cnt` and FSM update at that same edge.
  - With STABLE_N=1, they update at the sampling edge.
- `pair_stb` asserts at the edge the completing ones digit is accepted, and lasts exactly one cycle.
- Glitches and phases shorter than STABLE_N samples are ignored. They restart the run but cause no output change.
- `err_stb` and `pair_stb` cannot assert in the same cycle, since only one accept occurs per cycle.
- `err_cnt` at 255 stays at 255; `err_stb` still pulses.

## Structure
- **Package `sevenseg_pkg`:**
  - The ten segment constants plus SEG_BLANK (7'h00).
  - DIGIT_BLANK (4'hF).
  - `frame_state_t` enum (WAIT_T, WAIT_O).
  - Shared with the display driver so encode and decode use one table.
- **Sub-module `sevenseg_dec`:** purely combinational, `seg[6:0]` → `digit[3:0]`, `valid`. It is instantiated once on `s_q`. The run counter, FSM and error counter live in `sevenseg_rx`.

## Test plan
- **Reset:** assert reset with `seg_in` toggling → all outputs hold reset values. After release with `seg_in = 8'h86` held for 2 cycles → `tens=1`, `tens_vld=1` at the second edge, `pair_stb=0`.
- **Normal frame:** 2 cycles of 8'hDB then 2 cycles of 8'h4F → `tens=2`, `ones=3`, single `pair_stb` at the 4th edge. Repeating the identical frame gives no further `pair_stb`.
- **Glitch filter:** 8'h86 for 1 cycle among 8'h3F samples with STABLE_N=2 → no change, no strobe.
- **Invalid pattern:** 8'h01 held 2 cycles → `err_stb` one cycle, `err_cnt=1`, `ones` unchanged, FSM in WAIT_T. Applying it 300 times → `err_cnt=255`.
- **Out-of-order:** tens 5, tens 7, ones 0 → `pair_stb` with {7,0}. An orphan ones 4 in WAIT_T → `ones=4`, no `pair_stb`.
- **Blank:** 8'h80 then 8'h00 each held 2 cycles → `tens=ones=4'hF`, both `_vld=1`, `pair_stb` pulses once.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Shared seven-segment definitions: one encode/decode table for the display
// driver and the bus receiver.
package sevenseg_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] DIGIT_BLANK = 4'hF;

    typedef enum logic {
        WAIT_T = 1'b0,
        WAIT_O = 1'b1
    } frame_state_t;

endpackage

// File: rtl/sevenseg_dec.sv
// Combinational segment-pattern to digit decoder; all-off decodes to blank,
// anything outside the table is flagged invalid.
module sevenseg_dec
    import sevenseg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       valid
);

    always_comb begin
        digit = DIGIT_BLANK;
        valid = 1'b1;
        case (seg)
            SEG_0:     digit = 4'd0;
            SEG_1:     digit = 4'd1;
            SEG_2:     digit = 4'd2;
            SEG_3:     digit = 4'd3;
            SEG_4:     digit = 4'd4;
            SEG_5:     digit = 4'd5;
            SEG_6:     digit = 4'd6;
            SEG_7:     digit = 4'd7;
            SEG_8:     digit = 4'd8;
            SEG_9:     digit = 4'd9;
            SEG_BLANK: digit = DIGIT_BLANK;
            default:   valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/sevenseg_rx.sv
// Receiver for the multiplexed {select, segments} display bus: debounces each
// pattern, decodes it and rebuilds the tens/ones pair.
//
// state  | meaning
// WAIT_T | expecting a tens digit to open a frame
// WAIT_O | tens captured, waiting for the ones digit that completes the frame
module sevenseg_rx
    import sevenseg_pkg::*;
#(
    parameter int unsigned STABLE_N = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] seg_in,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       tens_vld,
    output logic       ones_vld,
    output logic       pair_stb,
    output logic       err_stb,
    output logic [7:0] err_cnt
);

    localparam logic [3:0] RUN_MAX = 4'(STABLE_N);

    logic [7:0]   s_q;
    logic [3:0]   run_q, run_d;
    logic         same;
    logic         accept;
    logic [7:0]   acc_byte;
    logic [3:0]   dec_digit;
    logic         dec_valid;

    frame_state_t state_q, state_d;
    logic [3:0]   tens_q, tens_d;
    logic [3:0]   ones_q, ones_d;
    logic         tens_vld_q, tens_vld_d;
    logic         ones_vld_q, ones_vld_d;
    logic [7:0]   last_q, last_d;
    logic         last_vld_q, last_vld_d;
    logic [7:0]   err_cnt_q, err_cnt_d;
    logic         pair_stb_q, pair_stb_d;
    logic         err_stb_q, err_stb_d;

    assign same = (seg_in == s_q);

    always_comb begin
        run_d = 4'd1;
        if (same) begin
            run_d = (run_q >= RUN_MAX) ? RUN_MAX : run_q + 4'd1;
        end
    end

    // A saturated run that stays identical is the only way to reach RUN_MAX twice.
    assign accept = (run_d == RUN_MAX) && !(same && (run_q == RUN_MAX));

    // With a one-sample window the accepted byte is the one arriving now; otherwise s_q already holds it.
    assign acc_byte = (STABLE_N == 1) ? seg_in : s_q;

    sevenseg_dec u_dec (
        .seg   (acc_byte[6:0]),
        .digit (dec_digit),
        .valid (dec_valid)
    );

    always_comb begin
        state_d    = state_q;
        tens_d     = tens_q;
        ones_d     = ones_q;
        tens_vld_d = tens_vld_q;
        ones_vld_d = ones_vld_q;
        last_d     = last_q;
        last_vld_d = last_vld_q;
        err_cnt_d  = err_cnt_q;
        pair_stb_d = 1'b0;
        err_stb_d  = 1'b0;
        if (accept) begin
            if (!dec_valid) begin
                err_stb_d = 1'b1;
                state_d   = WAIT_T;
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
            end else if (acc_byte[7]) begin
                tens_d     = dec_digit;
                tens_vld_d = 1'b1;
                state_d    = WAIT_O;
            end else begin
                ones_d     = dec_digit;
                ones_vld_d = 1'b1;
                if (state_q == WAIT_O) begin
                    state_d    = WAIT_T;
                    last_d     = {tens_q, dec_digit};
                    last_vld_d = 1'b1;
                    pair_stb_d = !last_vld_q || ({tens_q, dec_digit} != last_q);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_q        <= 8'h00;
            run_q      <= 4'd0;
            state_q    <= WAIT_T;
            tens_q     <= DIGIT_BLANK;
            ones_q     <= DIGIT_BLANK;
            tens_vld_q <= 1'b0;
            ones_vld_q <= 1'b0;
            last_q     <= 8'h00;
            last_vld_q <= 1'b0;
            err_cnt_q  <= 8'h00;
            pair_stb_q <= 1'b0;
            err_stb_q  <= 1'b0;
        end else begin
            s_q        <= seg_in;
            run_q      <= run_d;
            state_q    <= state_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            tens_vld_q <= tens_vld_d;
            ones_vld_q <= ones_vld_d;
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
            err_cnt_q  <= err_cnt_d;
            pair_stb_q <= pair_stb_d;
            err_stb_q  <= err_stb_d;
        end
    end

    assign tens     = tens_q;
    assign ones     = ones_q;
    assign tens_vld = tens_vld_q;
    assign ones_vld = ones_vld_q;
    assign pair_stb = pair_stb_q;
    assign err_stb  = err_stb_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_sevenseg_rx.sv
// Scoreboard bench for sevenseg_rx: a run-length reference model predicts
// strobes and levels; a monitor checks the DUT after every clock edge.
module tb_sevenseg_rx;

    localparam int N = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] seg_in = 8'h00;
    logic [3:0] tens, ones;
    logic       tens_vld, ones_vld, pair_stb, err_stb;
    logic [7:0] err_cnt;

    sevenseg_rx #(.STABLE_N(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .seg_in   (seg_in),
        .tens     (tens),
        .ones     (ones),
        .tens_vld (tens_vld),
        .ones_vld (ones_vld),
        .pair_stb (pair_stb),
        .err_stb  (err_stb),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit   is_err;
        int   cyc;
        int   t;
        int   o;
        int   e;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model state
    int   run_len = 0;
    logic [7:0] prev = 8'h00;
    int   m_tens = 15, m_ones = 15, m_tv = 0, m_ov = 0, m_err = 0;
    bit   m_await_ones = 0;
    int   m_last = -1;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic bit mdl_dec(input logic [6:0] s, output int d);
        logic [6:0] tbl [10];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        d = 15;
        if (s == 7'h00) return 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (tbl[i] == s) begin
                d = i;
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic logic [7:0] enc(input bit sel, input int d);
        logic [6:0] tbl [10];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        if (d > 9) return {sel, 7'h00};
        return {sel, tbl[d]};
    endfunction

    task automatic model_accept(input logic [7:0] v);
        int   d;
        exp_t e;
        if (!mdl_dec(v[6:0], d)) begin
            m_err = (m_err < 255) ? m_err + 1 : 255;
            m_await_ones = 0;
            e = '{1'b1, cyc + 1, 0, 0, m_err};
            q.push_back(e);
        end else if (v[7]) begin
            m_tens = d;
            m_tv = 1;
            m_await_ones = 1;
        end else begin
            m_ones = d;
            m_ov = 1;
            if (m_await_ones) begin
                m_await_ones = 0;
                if (m_last != m_tens * 16 + d) begin
                    e = '{1'b0, cyc + 1, m_tens, d, 0};
                    q.push_back(e);
                end
                m_last = m_tens * 16 + d;
            end
        end
    endtask

    task automatic model_step(input logic [7:0] v, input bit r);
        if (r) begin
            run_len = 0;
            m_tens = 15; m_ones = 15; m_tv = 0; m_ov = 0; m_err = 0;
            m_await_ones = 0;
            m_last = -1;
            return;
        end
        if (run_len > 0 && v == prev) run_len++;
        else run_len = 1;
        prev = v;
        if (run_len == N) model_accept(v);
    endtask

    // One clock cycle: drive at the falling edge, return just after the rising edge.
    task automatic drive(input logic [7:0] v, input bit r);
        @(negedge clk);
        seg_in = v;
        reset = r;
        model_step(v, r);
        @(posedge clk);
        #2;
    endtask

    task automatic hold(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) drive(v, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            chk("tens", int'(tens), m_tens);
            chk("ones", int'(ones), m_ones);
            chk("tens_vld", int'(tens_vld), m_tv);
            chk("ones_vld", int'(ones_vld), m_ov);
            chk("err_cnt", int'(err_cnt), m_err);
            if (pair_stb || err_stb) begin
                chk("strobe_excl", int'(pair_stb && err_stb), 0);
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: pair_stb=%0b err_stb=%0b, none expected (cycle %0d)",
                             pair_stb, err_stb, cyc);
                end else begin
                    e = q.pop_front();
                    chk("stb_cycle", cyc, e.cyc);
                    chk("stb_kind_err", int'(err_stb), int'(e.is_err));
                    if (!e.is_err) begin
                        chk("pair_tens", int'(tens), e.t);
                        chk("pair_ones", int'(ones), e.o);
                    end else begin
                        chk("err_stb_cnt", int'(err_cnt), e.e);
                    end
                end
            end
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_strobe: got none, expected %s at cycle %0d",
                         e.is_err ? "err_stb" : "pair_stb", e.cyc);
            end
        end
    end

    initial begin : stim
        int kind, d, len;
        logic [7:0] v;
        logic [6:0] s;

        // Reset held with a toggling bus
        for (int i = 0; i < 4; i++) drive(8'($urandom), 1'b1);
        hold(8'h86, 1);
        chk("rst_tens_first_edge", int'(tens), 15);
        hold(8'h86, 1);
        chk("rst_tens_accept", int'(tens), 1);
        chk("rst_tens_vld", int'(tens_vld), 1);

        // Normal frame, then identical repeat
        hold(8'hDB, 2);
        hold(8'h4F, 2);
        chk("frame_tens", int'(tens), 2);
        chk("frame_ones", int'(ones), 3);
        hold(8'hDB, 2);
        hold(8'h4F, 2);

        // Single-cycle glitch among ones-0 samples
        hold(8'h3F, 2);
        hold(8'h86, 1);
        hold(8'h3F, 2);
        chk("glitch_tens", int'(tens), 2);

        // Invalid pattern
        hold(8'h01, 2);
        chk("inv_err_cnt", int'(err_cnt), 1);
        chk("inv_ones", int'(ones), 0);

        // Out-of-order tens, then orphan ones
        hold(8'hED, 2);
        hold(8'h87, 2);
        hold(8'h3F, 2);
        chk("ooo_tens", int'(tens), 7);
        chk("ooo_ones", int'(ones), 0);
        hold(8'h66, 2);
        chk("orphan_ones", int'(ones), 4);

        // Blank frame
        hold(8'h80, 2);
        hold(8'h00, 2);
        chk("blank_tens", int'(tens), 15);
        chk("blank_ones", int'(ones), 15);

        // Randomized traffic with glitches, invalid codes and occasional resets
        for (int i = 0; i < 400; i++) begin
            kind = $urandom_range(0, 99);
            if (kind < 2) begin
                drive(8'($urandom), 1'b1);
                continue;
            end else if (kind < 80) begin
                d = $urandom_range(0, 10);
                v = enc(1'($urandom_range(0, 1)), d);
            end else begin
                s = 7'($urandom_range(1, 127));
                if (mdl_dec(s, d)) s = 7'h01;
                v = {1'($urandom_range(0, 1)), s};
            end
            len = $urandom_range(1, 3);
            hold(v, len);
        end

        // Reset mid-run discards the partial run
        hold(8'h00, 2);
        drive(8'hDB, 1'b0);
        drive(8'hDB, 1'b1);
        hold(8'hDB, 1);
        chk("midrun_no_accept", int'(tens_vld), 0);
        hold(8'hDB, 1);
        chk("midrun_accept", int'(tens), 2);

        // Error counter saturation
        for (int i = 0; i < 150; i++) begin
            hold(8'h01, 2);
            hold(8'h81, 2);
        end
        chk("err_sat", int'(err_cnt), 255);

        hold(8'h00, 4);
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
